// File: rtl/div_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg : shared types and constants for the restoring divider
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package div_pkg;

  localparam int DIV_N      = 8;
  localparam int DIVIDEND_W = 2 * DIV_N;
  localparam int ITER       = 2 * DIV_N;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/divide_if.sv
// ---------------------------------------------------------------------------
// divide_if : request/result bundle of the divider
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface divide_if
  import div_pkg::*;
#(
  parameter int N = DIV_N
) ();

  logic           start;
  logic [2*N-1:0] dividend;
  logic [N-1:0]   divisor;
  logic [2*N-1:0] QT;
  logic [N-1:0]   RM;
  logic           DZ;
  logic           Ready;

  modport master (
    output start, dividend, divisor,
    input  QT, RM, DZ, Ready
  );

  modport slave (
    input  start, dividend, divisor,
    output QT, RM, DZ, Ready
  );

endinterface

`default_nettype wire

// File: rtl/div_step.sv
// ---------------------------------------------------------------------------
// div_step : one combinational shift / trial-subtract / restore step
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module div_step
  import div_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic [N:0]   rem_i,
  input  logic         bit_i,
  input  logic [N-1:0] divisor_i,
  output logic [N:0]   rem_o,
  output logic         q_o
);

  logic [N:0]   shifted_w;
  logic [N+1:0] diff_w;

  assign shifted_w = {rem_i[N-1:0], bit_i};
  assign diff_w    = {1'b0, shifted_w} - {2'b00, divisor_i};

  // A bit shifted out of the top means the true value exceeds any divisor,
  // so the subtraction is valid and the low N+1 bits of the difference are exact.
  assign q_o   = rem_i[N] | ~diff_w[N+1];
  assign rem_o = q_o ? diff_w[N:0] : shifted_w;

endmodule

`default_nettype wire

// File: rtl/divide.sv
// ---------------------------------------------------------------------------
// divide : sequential restoring divider, 2N-bit / N-bit, one bit per cycle
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module divide
  import div_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic     clock,
  input  logic     reset,
  divide_if.slave  bus
);

  localparam int DW    = 2 * N;
  localparam int STEPS = 2 * N;
  localparam int CW    = $clog2(STEPS);
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [DW-1:0]   dvd_q;
  logic [N-1:0]    dvs_q;
  logic [N:0]      rem_q;
  logic [DW-1:0]   qt_q;
  logic [N-1:0]    rm_q;
  logic            dz_q;
  logic            ready_q;

  logic [N:0]      rem_d;
  logic            qbit_d;
  logic [DW-1:0]   dvd_d;

  div_step #(.N(N)) u_step (
    .rem_i     (rem_q),
    .bit_i     (dvd_q[DW-1]),
    .divisor_i (dvs_q),
    .rem_o     (rem_d),
    .q_o       (qbit_d)
  );

  // Dividend bits leave from the top while quotient bits enter at the bottom.
  assign dvd_d = {dvd_q[DW-2:0], qbit_d};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      qt_q    <= '0;
      rm_q    <= '0;
      dz_q    <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            dvd_q   <= bus.dividend;
            dvs_q   <= bus.divisor;
            rem_q   <= '0;
            cnt_q   <= '0;
            state_q <= BUSY;
            ready_q <= 1'b0;
          end
        end
        BUSY: begin
          dvd_q <= dvd_d;
          rem_q <= rem_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            qt_q    <= dvd_d;
            rm_q    <= rem_d[N-1:0];
            dz_q    <= (dvs_q == '0);
            state_q <= DONE;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.QT    = qt_q;
  assign bus.RM    = rm_q;
  assign bus.DZ    = dz_q;
  assign bus.Ready = ready_q;

endmodule

`default_nettype wire

// File: tb/tb_divide.sv
// ---------------------------------------------------------------------------
// tb_divide : self-checking bench for the restoring divider
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_divide;

  localparam int N   = 8;
  localparam int LAT = 2 * N;
  localparam int MAX_WAIT = 60;

  logic clk;
  logic rst_n;

  divide_if #(.N(N)) bus ();

  divide #(.N(N)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [15:0] dvd;
    logic [7:0]  dvs;
    logic [15:0] qt;
    logic [7:0]  rm;
    logic        dz;
  } vec_t;

  logic [15:0] got_qt;
  logic [7:0]  got_rm;
  logic        got_dz;
  int          got_lat;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Reference: plain integer division with the divide-by-zero convention.
  task automatic model(input logic [15:0] a, input logic [7:0] b,
                       output logic [15:0] q, output logic [7:0] r, output logic z);
    if (b == 0) begin
      q = 16'hFFFF;
      r = a[7:0];
      z = 1'b1;
    end else begin
      q = a / {8'd0, b};
      r = 8'(a % {8'd0, b});
      z = 1'b0;
    end
  endtask

  task automatic wait_ready(output int lat);
    lat = 0;
    while (bus.Ready !== 1'b1 && lat < MAX_WAIT) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  // Present one request, check that it is accepted, then collect the result.
  task automatic run_op(input logic [15:0] a, input logic [7:0] b);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk);
    #1;
    check("accept_ready_low", 32'(bus.Ready), 32'd0);
    bus.start    = 1'b0;
    bus.dividend = 16'(($urandom));
    bus.divisor  = 8'($urandom);
    wait_ready(got_lat);
    check("latency", got_lat, LAT);
    got_qt = bus.QT;
    got_rm = bus.RM;
    got_dz = bus.DZ;
  endtask

  task automatic check_vs_model(input string tag, input logic [15:0] a, input logic [7:0] b);
    logic [15:0] eq;
    logic [7:0]  er;
    logic        ez;
    model(a, b, eq, er, ez);
    check({tag, "_qt"}, 32'(got_qt), 32'(eq));
    check({tag, "_rm"}, 32'(got_rm), 32'(er));
    check({tag, "_dz"}, 32'(got_dz), 32'(ez));
    if (b != 0) begin
      check({tag, "_identity"}, 32'(got_qt) * 32'(b) + 32'(got_rm), 32'(a));
      check({tag, "_rm_lt_dvs"}, 32'(got_rm < b), 32'd1);
    end
  endtask

  vec_t vecs[5];

  initial begin
    logic [15:0] eq;
    logic [7:0]  er;
    logic        ez;
    logic [15:0] sweep_dvd[6];
    int lat;

    vecs[0] = '{dvd: 16'd12,    dvs: 8'd4,  qt: 16'd3,     rm: 8'd0,   dz: 1'b0};
    vecs[1] = '{dvd: 16'd1000,  dvs: 8'd7,  qt: 16'd142,   rm: 8'd6,   dz: 1'b0};
    vecs[2] = '{dvd: 16'd65535, dvs: 8'd1,  qt: 16'd65535, rm: 8'd0,   dz: 1'b0};
    vecs[3] = '{dvd: 16'd400,   dvs: 8'd0,  qt: 16'hFFFF,  rm: 8'h90,  dz: 1'b1};
    vecs[4] = '{dvd: 16'd400,   dvs: 8'd20, qt: 16'd20,    rm: 8'd0,   dz: 1'b0};
    sweep_dvd = '{16'd0, 16'd1, 16'd255, 16'd256, 16'd12345, 16'd65535};

    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", 32'(bus.Ready), 32'd1);
    check("reset_qt",    32'(bus.QT),    32'd0);
    check("reset_rm",    32'(bus.RM),    32'd0);
    check("reset_dz",    32'(bus.DZ),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_ready", 32'(bus.Ready), 32'd1);

    // Directed table
    for (int i = 0; i < 5; i++) begin
      run_op(vecs[i].dvd, vecs[i].dvs);
      check($sformatf("vec%0d_qt", i), 32'(got_qt), 32'(vecs[i].qt));
      check($sformatf("vec%0d_rm", i), 32'(got_rm), 32'(vecs[i].rm));
      check($sformatf("vec%0d_dz", i), 32'(got_dz), 32'(vecs[i].dz));
    end

    // Results hold in DONE while start stays low and inputs wander
    repeat (4) begin
      @(negedge clk);
      bus.dividend = 16'($urandom);
      bus.divisor  = 8'($urandom);
    end
    #1;
    check("hold_ready", 32'(bus.Ready), 32'd1);
    check("hold_qt", 32'(bus.QT), 32'd20);
    check("hold_rm", 32'(bus.RM), 32'd0);

    // Reset mid-operation: abort, Ready rises asynchronously, held start restarts
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 16'd400;
    bus.divisor  = 8'd20;
    #39;
    check("pre_reset_busy", 32'(bus.Ready), 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset_ready", 32'(bus.Ready), 32'd1);
    check("async_reset_qt",    32'(bus.QT),    32'd0);
    check("async_reset_rm",    32'(bus.RM),    32'd0);
    #9;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("restart_accept", 32'(bus.Ready), 32'd0);
    bus.start = 1'b0;
    wait_ready(lat);
    check("restart_latency", lat, LAT);
    check("restart_qt", 32'(bus.QT), 32'd20);
    check("restart_rm", 32'(bus.RM), 32'd0);
    check("restart_dz", 32'(bus.DZ), 32'd0);

    // Back-to-back: start held across DONE, inputs change during BUSY
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 16'd50000;
    bus.divisor  = 8'd123;
    @(posedge clk);
    #1;
    check("b2b_accept1", 32'(bus.Ready), 32'd0);
    bus.dividend = 16'd777;
    bus.divisor  = 8'd5;
    wait_ready(lat);
    check("b2b_latency1", lat, LAT);
    model(16'd50000, 8'd123, eq, er, ez);
    check("b2b_qt1", 32'(bus.QT), 32'(eq));
    check("b2b_rm1", 32'(bus.RM), 32'(er));
    @(posedge clk);
    #1;
    check("b2b_no_idle", 32'(bus.Ready), 32'd0);
    bus.start    = 1'b0;
    bus.dividend = 16'd9;
    bus.divisor  = 8'd0;
    wait_ready(lat);
    check("b2b_latency2", lat, LAT);
    model(16'd777, 8'd5, eq, er, ez);
    check("b2b_qt2", 32'(bus.QT), 32'(eq));
    check("b2b_rm2", 32'(bus.RM), 32'(er));
    check("b2b_dz2", 32'(bus.DZ), 32'(ez));

    // Randomized operands against the reference
    for (int i = 0; i < 60; i++) begin
      logic [15:0] a;
      logic [7:0]  b;
      a = 16'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      run_op(a, b);
      check_vs_model("rand", a, b);
    end

    // Exhaustive divisor sweep over selected dividends
    for (int d = 0; d < 6; d++) begin
      for (int s = 0; s < 256; s++) begin
        run_op(sweep_dvd[d], 8'(s));
        check_vs_model("sweep", sweep_dvd[d], 8'(s));
      end
    end

    if (n_err == 0) $display("All tests passed.");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
